gpio_port: RTL and testbench
============================

Name: gpio_port

Overview:
- Parametrised successor to the output-only parallel port: a bus-attached bidirectional GPIO bank of WIDTH pins.
- Adds per-pin direction, atomic set/clear/toggle writes, synchronised input sampling, and edge-detect status with a level interrupt.
- Sits behind a bus_hub_N device slot, on the same clock as the core. Drives LEDs and matrix columns and reads keys on the iceFUN.

Parameters:
- WIDTH, 32, number of pins (1..32); register bits at and above WIDTH read 0 and ignore writes.
- RESET_OUT, 32'h0, reset value of the OUT register (low WIDTH bits used).
- RESET_DIR, 32'hFFFF_FFFF, reset value of DIR; 1 = output, so default behaviour matches the old output-only port.
- SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- addr  in  32  byte address from hub; only addr[5:2] decoded
- wdata  in  32  write data
- wmask  in  4  byte write enables
- ren  in  1  read strobe
- wen  in  1  write strobe
- active  in  1  hub select; strobes are ignored unless active=1
- rdata  out  32  read data, valid when ready=1
- ready  out  1  one-cycle transfer-done pulse
- io_out  out  WIDTH  pin output values (= OUT)
- io_oe  out  WIDTH  pin output enables (= DIR)
- io_in  in  WIDTH  asynchronous pin inputs
- irq  out  1  level interrupt

Behaviour:
- Reset (rst=1 at a clk edge):
  - OUT=RESET_OUT, DIR=RESET_DIR.
  - RISE_EN=FALL_EN=STATUS=IRQ_EN=0.
  - Synchroniser and previous-sample registers reset to 0.
  - ready=0, rdata=0, irq=0.
  - A transfer in flight when reset arrives is dropped; no ready is issued.
- Handshake:
  - A strobe (ren or wen, with active=1) sampled at edge N produces ready=1 for exactly the cycle after edge N.
  - Writes take effect at edge N. rdata is registered and valid while ready=1, then returns to 0.
  - If ren and wen are both high, the write is performed and rdata returns the pre-write value.
  - Strobes held high for several cycles are treated as a new request each cycle.
  - Unmapped offsets: writes are ignored, reads return 0, ready still pulses.
- Register map (word offset = addr[5:2]):
  - 0 OUT: rw.
  - 1 OUT_SET: write sets OUT |= wdata; reads return OUT.
  - 2 OUT_CLR: write applies OUT &= ~wdata; reads return OUT.
  - 3 OUT_TGL: write applies OUT ^= wdata; reads return OUT.
  - 4 DIR: rw.
  - 5 IN: ro; synchronised input.
  - 6 RISE_EN: rw.
  - 7 FALL_EN: rw.
  - 8 STATUS: read returns status; write 1 clears the bit (w1c).
  - 9 IRQ_EN: rw, bit0 only.
- wmask rule: every write type (plain, set, clear, toggle, w1c) only affects bytes whose wmask bit is set. For example, OUT_SET with wmask=4'b0001 changes OUT[7:0] only.
- Input path:
  - sync = SYNC_STAGES-flop chain on io_in, so IN lags the pins by SYNC_STAGES cycles.
  - prev = sync delayed by one cycle.
  - rise = sync & ~prev & RISE_EN; fall = ~sync & prev & FALL_EN.
  - STATUS bit i is set on rise[i] | fall[i]. Edges are detected regardless of DIR, so output pins looped back through io_in also flag edges.
  - If an edge and a w1c of the same bit occur in the same cycle, the set wins and the bit stays 1.
- irq = registered (|(STATUS & WIDTH mask)) & IRQ_EN[0]; it updates one cycle after STATUS changes.
- No counters wrap. All arithmetic is bitwise and WIDTH-bit wide; reads zero-extend to 32 bits.

Decomposition:
- Shared package gpio_pkg holds:
  - register offset localparams: GPIO_OUT, GPIO_SET, GPIO_CLR, GPIO_TGL, GPIO_DIR, GPIO_IN, GPIO_RISE, GPIO_FALL, GPIO_STAT, GPIO_IRQEN;
  - a function expanding wmask into a 32-bit bit mask.
- One natural sub-module: gpio_sync, a parametrised WIDTH x SYNC_STAGES synchroniser with previous-sample register and rise/fall outputs.
- All other logic stays in gpio_port.

Test Plan:
- Reset check: hold rst 2 cycles -> io_out=0, io_oe=32'hFFFF_FFFF, irq=0, ready=0. Read offset 4 -> ready one cycle after the strobe, rdata=32'hFFFF_FFFF.
- Atomic writes:
  - write OUT=32'h0000_00F0, SET 32'h0F, CLR 32'h30, TGL 32'h101 -> read OUT=32'h0000_01CE;
  - SET 32'hFFFF_FFFF with wmask=4'b0010 -> OUT=32'h0000_FFCE.
- Input latency: DIR=0, drive io_in=32'hA5 at edge T -> IN reads 32'h0 if sampled before T+SYNC_STAGES and 32'hA5 after.
- Edge/irq:
  - RISE_EN=1, IRQ_EN=1, pulse io_in[0] 0->1 -> STATUS=1, and irq rises SYNC_STAGES+2 cycles after the pin edge;
  - w1c STATUS=1 -> irq falls next cycle.
- Set/clear collision: a rising edge on bit 3 reaches STATUS in the same cycle as a w1c of bit 3 -> STATUS[3]=1 after, irq stays high.
- Bus corners:
  - wen with active=0 -> no change, no ready;
  - read offset 12 -> rdata=0, ready pulses;
  - rst asserted the cycle after wen -> no ready, registers at reset values;
  - WIDTH=12 build -> OUT write 32'hFFFF_FFFF reads back 32'h0000_0FFF.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared register offsets and bus helpers for the gpio_port bank.
package gpio_pkg;

  localparam logic [3:0] GPIO_OUT   = 4'd0;
  localparam logic [3:0] GPIO_SET   = 4'd1;
  localparam logic [3:0] GPIO_CLR   = 4'd2;
  localparam logic [3:0] GPIO_TGL   = 4'd3;
  localparam logic [3:0] GPIO_DIR   = 4'd4;
  localparam logic [3:0] GPIO_IN    = 4'd5;
  localparam logic [3:0] GPIO_RISE  = 4'd6;
  localparam logic [3:0] GPIO_FALL  = 4'd7;
  localparam logic [3:0] GPIO_STAT  = 4'd8;
  localparam logic [3:0] GPIO_IRQEN = 4'd9;

  // Expands the four byte enables into a per-bit write mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] wmask);
    byte_mask = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage input synchroniser with a previous-sample register and
// enable-qualified rising/falling edge strobes.
module gpio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] io_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      prev_q <= '0;
    end else begin
      chain[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev_q <= chain[SYNC_STAGES-1];
    end
  end

  assign sync_q = chain[SYNC_STAGES-1];
  assign rise   = sync_q & ~prev_q & rise_en;
  assign fall   = ~sync_q & prev_q & fall_en;

endmodule

// File: rtl/gpio_port.sv
// Bus-attached bidirectional GPIO bank: atomic OUT updates, per-pin direction,
// synchronised inputs and edge-detect status driving a level interrupt.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_OUT   = 32'h0,
  parameter logic [31:0] RESET_DIR   = 32'hFFFF_FFFF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wmask,
  input  logic             ren,
  input  logic             wen,
  input  logic             active,
  output logic [31:0]      rdata,
  output logic             ready,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oe,
  input  logic [WIDTH-1:0] io_in,
  output logic             irq
);

  logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q;
  logic             irq_en_q;
  logic [WIDTH-1:0] out_d, status_d;
  logic [WIDTH-1:0] sync_q, rise, fall;
  logic [WIDTH-1:0] bit_mask, wbits;
  logic [31:0]      full_mask, rd_val;
  logic [3:0]       off;
  logic             rd, wr;
  logic             unused_bits;

  assign off       = addr[5:2];
  assign rd        = active & ren;
  assign wr        = active & wen;
  assign full_mask = byte_mask(wmask);
  assign bit_mask  = full_mask[WIDTH-1:0];
  assign wbits     = wdata[WIDTH-1:0] & bit_mask;

  assign unused_bits = ^{addr[31:6], addr[1:0], wdata, full_mask};

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .io_in   (io_in),
    .rise_en (rise_en_q),
    .fall_en (fall_en_q),
    .sync_q  (sync_q),
    .rise    (rise),
    .fall    (fall)
  );

  always_comb begin
    out_d = out_q;
    if (wr) begin
      case (off)
        GPIO_OUT: out_d = (out_q & ~bit_mask) | wbits;
        GPIO_SET: out_d = out_q | wbits;
        GPIO_CLR: out_d = out_q & ~wbits;
        GPIO_TGL: out_d = out_q ^ wbits;
        default:  out_d = out_q;
      endcase
    end
  end

  // Edge set is applied after the w1c clear so a simultaneous edge wins.
  always_comb begin
    status_d = status_q;
    if (wr && off == GPIO_STAT) status_d = status_q & ~wbits;
    status_d = status_d | rise | fall;
  end

  always_comb begin
    rd_val = '0;
    case (off)
      GPIO_OUT, GPIO_SET, GPIO_CLR, GPIO_TGL: rd_val[WIDTH-1:0] = out_q;
      GPIO_DIR:   rd_val[WIDTH-1:0] = dir_q;
      GPIO_IN:    rd_val[WIDTH-1:0] = sync_q;
      GPIO_RISE:  rd_val[WIDTH-1:0] = rise_en_q;
      GPIO_FALL:  rd_val[WIDTH-1:0] = fall_en_q;
      GPIO_STAT:  rd_val[WIDTH-1:0] = status_q;
      GPIO_IRQEN: rd_val[0]         = irq_en_q;
      default:    rd_val            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= RESET_OUT[WIDTH-1:0];
      dir_q     <= RESET_DIR[WIDTH-1:0];
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_en_q  <= 1'b0;
      irq       <= 1'b0;
      ready     <= 1'b0;
      rdata     <= '0;
    end else begin
      out_q    <= out_d;
      status_q <= status_d;
      irq      <= (|status_q) & irq_en_q;
      ready    <= rd | wr;
      rdata    <= rd ? rd_val : 32'h0;
      if (wr) begin
        case (off)
          GPIO_DIR:   dir_q     <= (dir_q & ~bit_mask) | wbits;
          GPIO_RISE:  rise_en_q <= (rise_en_q & ~bit_mask) | wbits;
          GPIO_FALL:  fall_en_q <= (fall_en_q & ~bit_mask) | wbits;
          GPIO_IRQEN: if (wmask[0]) irq_en_q <= wdata[0];
          default: ;
        endcase
      end
    end
  end

  assign io_out = out_q;
  assign io_oe  = dir_q;

endmodule

// File: tb/tb_gpio_port.sv
// Directed self-checking bench for gpio_port (32-bit instance plus a 12-bit build).
module tb_gpio_port;
  import gpio_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic        active = 1'b0;
  logic        active12 = 1'b0;
  logic [31:0] rdata, rdata12;
  logic        ready, ready12;
  logic [31:0] io_out, io_oe;
  logic [31:0] io_in = '0;
  logic [11:0] io_out12, io_oe12;
  logic [11:0] io_in12 = '0;
  logic        irq, irq12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_port dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wmask(wmask),
    .ren(ren), .wen(wen), .active(active), .rdata(rdata), .ready(ready),
    .io_out(io_out), .io_oe(io_oe), .io_in(io_in), .irq(irq)
  );

  gpio_port #(.WIDTH(12)) dut12 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wmask(wmask),
    .ren(ren), .wen(wen), .active(active12), .rdata(rdata12), .ready(ready12),
    .io_out(io_out12), .io_oe(io_oe12), .io_in(io_in12), .irq(irq12)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // One bus transfer: strobe sampled at the next posedge, outputs sampled 1 time unit later.
  task automatic bus_xfer(input logic [3:0] off, input logic [31:0] data, input logic [3:0] mask,
                          input logic do_rd, input logic do_wr, input logic narrow,
                          output logic rdy, output logic [31:0] rd);
    @(negedge clk);
    addr = {26'b0, off, 2'b00};
    wdata = data; wmask = mask; ren = do_rd; wen = do_wr;
    active = !narrow; active12 = narrow;
    @(posedge clk);
    #1;
    rdy = narrow ? ready12 : ready;
    rd  = narrow ? rdata12 : rdata;
    ren = 1'b0; wen = 1'b0; active = 1'b0; active12 = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [31:0] data, input logic [3:0] mask,
                           output logic rdy);
    logic [31:0] unused_rd;
    bus_xfer(off, data, mask, 1'b0, 1'b1, 1'b0, rdy, unused_rd);
  endtask

  task automatic bus_read(input logic [3:0] off, output logic rdy, output logic [31:0] rd);
    bus_xfer(off, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, rdy, rd);
  endtask

  task automatic test_reset;
    logic rdy; logic [31:0] rd;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (io_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_io_out: got %h expected %h", io_out, 32'h0); end
    checks++; if (io_oe !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL reset_io_oe: got %h expected %h", io_oe, 32'hFFFF_FFFF); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
    bus_read(GPIO_DIR, rdy, rd);
    checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_dir_ready: got %b expected 1", rdy); end
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL reset_dir_rdata: got %h expected %h", rd, 32'hFFFF_FFFF); end
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0 || rdata !== 32'h0) begin errors++; $display("[TB] FAIL ready_pulse_end: got ready=%b rdata=%h expected ready=0 rdata=0", ready, rdata); end
  endtask

  task automatic test_atomic;
    logic rdy; logic [31:0] rd;
    bus_write(GPIO_OUT, 32'h0000_00F0, 4'hF, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL write_ready: got %b expected 1", rdy); end
    checks++; if (io_out !== 32'h0000_00F0) begin errors++; $display("[TB] FAIL write_effect: got %h expected %h", io_out, 32'h0000_00F0); end
    bus_write(GPIO_SET, 32'h0000_000F, 4'hF, rdy);
    bus_write(GPIO_CLR, 32'h0000_0030, 4'hF, rdy);
    bus_write(GPIO_TGL, 32'h0000_0101, 4'hF, rdy);
    bus_read(GPIO_OUT, rdy, rd);
    checks++; if (rd !== 32'h0000_01CE) begin errors++; $display("[TB] FAIL atomic_seq: got %h expected %h", rd, 32'h0000_01CE); end
    bus_write(GPIO_SET, 32'hFFFF_FFFF, 4'b0010, rdy);
    bus_read(GPIO_SET, rdy, rd);
    checks++; if (rd !== 32'h0000_FFCE) begin errors++; $display("[TB] FAIL set_wmask: got %h expected %h", rd, 32'h0000_FFCE); end
    bus_xfer(GPIO_OUT, 32'h0000_1234, 4'hF, 1'b1, 1'b1, 1'b0, rdy, rd);
    checks++; if (rd !== 32'h0000_FFCE) begin errors++; $display("[TB] FAIL rw_prewrite: got %h expected %h", rd, 32'h0000_FFCE); end
    checks++; if (io_out !== 32'h0000_1234) begin errors++; $display("[TB] FAIL rw_write: got %h expected %h", io_out, 32'h0000_1234); end
  endtask

  // Pins driven 1 time unit after edge T; a read strobed at T+2 still sees 0, at T+3 sees the value.
  task automatic test_input_latency;
    logic rdy; logic [31:0] rd0, rd1, rd2;
    bus_write(GPIO_DIR, 32'h0, 4'hF, rdy);
    checks++; if (io_oe !== 32'h0) begin errors++; $display("[TB] FAIL dir_write: got %h expected 0", io_oe); end
    io_in = 32'h0000_00A5;
    bus_read(GPIO_IN, rdy, rd0);
    bus_read(GPIO_IN, rdy, rd1);
    bus_read(GPIO_IN, rdy, rd2);
    checks++; if (rd0 !== 32'h0) begin errors++; $display("[TB] FAIL in_lat_t1: got %h expected 0", rd0); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("[TB] FAIL in_lat_t2: got %h expected 0", rd1); end
    checks++; if (rd2 !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL in_lat_t3: got %h expected %h", rd2, 32'h0000_00A5); end
  endtask

  task automatic test_edge_irq;
    logic rdy; logic [31:0] rd;
    io_in = 32'h0;
    repeat (5) @(posedge clk);
    bus_write(GPIO_RISE, 32'h1, 4'hF, rdy);
    bus_write(GPIO_IRQEN, 32'h1, 4'hF, rdy);
    @(posedge clk); #1;
    io_in[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (irq !== (k == 4)) begin errors++; $display("[TB] FAIL irq_latency_%0d: got %b expected %b", k, irq, (k == 4)); end
    end
    bus_read(GPIO_STAT, rdy, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("[TB] FAIL status_rise: got %h expected 1", rd); end
    bus_write(GPIO_STAT, 32'h1, 4'hF, rdy);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_hold_w1c_edge: got %b expected 1", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_fall: got %b expected 0", irq); end
  endtask

  task automatic test_collision;
    logic rdy; logic [31:0] rd;
    bus_write(GPIO_RISE, 32'h9, 4'hF, rdy);
    io_in[3] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL collision_setup_irq: got %b expected 1", irq); end
    io_in[3] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    io_in[3] = 1'b1;
    repeat (2) @(posedge clk);
    bus_write(GPIO_STAT, 32'h8, 4'hF, rdy);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (irq !== 1'b1) begin errors++; $display("[TB] FAIL collision_irq_%0d: got %b expected 1", k, irq); end
      @(posedge clk); #1;
    end
    bus_read(GPIO_STAT, rdy, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("[TB] FAIL collision_status: got %h expected 8", rd); end
  endtask

  task automatic test_bus_corners;
    logic rdy; logic [31:0] rd;
    @(negedge clk);
    addr = 32'h0; wdata = 32'hDEAD_BEEF; wmask = 4'hF; wen = 1'b1; active = 1'b0;
    @(posedge clk); #1;
    wen = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL inactive_ready: got %b expected 0", ready); end
    checks++; if (io_out !== 32'h0000_1234) begin errors++; $display("[TB] FAIL inactive_write: got %h expected %h", io_out, 32'h0000_1234); end
    bus_read(4'd12, rdy, rd);
    checks++; if (rdy !== 1'b1 || rd !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_read: got ready=%b rdata=%h expected ready=1 rdata=0", rdy, rd); end
    bus_xfer(GPIO_OUT, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 1'b1, rdy, rd);
    bus_xfer(GPIO_OUT, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, rdy, rd);
    checks++; if (rd !== 32'h0000_0FFF) begin errors++; $display("[TB] FAIL width12_read: got %h expected %h", rd, 32'h0000_0FFF); end
    checks++; if (io_out12 !== 12'hFFF) begin errors++; $display("[TB] FAIL width12_io_out: got %h expected fff", io_out12); end
  endtask

  task automatic test_drop_on_reset;
    @(negedge clk);
    addr = 32'h0; wdata = 32'h55; wmask = 4'hF; wen = 1'b1; active = 1'b1;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0; active = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL drop_ready: got %b expected 0", ready); end
    checks++; if (io_out !== 32'h0) begin errors++; $display("[TB] FAIL drop_io_out: got %h expected 0", io_out); end
    checks++; if (io_oe !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL drop_io_oe: got %h expected %h", io_oe, 32'hFFFF_FFFF); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL drop_irq: got %b expected 0", irq); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL drop_late_ready: got %b expected 0", ready); end
  endtask

  initial begin
    $display("[TB] starting gpio_port bench");
    test_reset();
    test_atomic();
    test_input_latency();
    test_edge_irq();
    test_collision();
    test_bus_corners();
    test_drop_on_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
